// File: rtl/prefix_adder_pipe.sv
// Pipelined parallel-prefix adder (serial/Sklansky/Kogge-Stone); `PREFIX_ADDER_SUB_EN adds sub/ovf.
// Latency: STAGES cycles from accept to out_valid when out_ready stays high.
// Backpressure: per-stage valid with bubble collapse; in_ready = some stage empty or out_ready.
module prefix_adder_pipe #(
    parameter int WIDTH    = 32,
    parameter int TOPOLOGY = 1,
    parameter int STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int LEVELS = (TOPOLOGY == 0) ? WIDTH - 1 : $clog2(WIDTH);

    // Column whose group term is merged into column col at level lvl; -1 means pass through.
    function automatic int partner(int lvl, int col);
        if (TOPOLOGY == 0) return (col == lvl) ? col - 1 : -1;
        if (TOPOLOGY == 1) return (((col >> (lvl - 1)) & 1) != 0) ? ((col >> (lvl - 1)) << (lvl - 1)) - 1 : -1;
        return (col >= (1 << (lvl - 1))) ? col - (1 << (lvl - 1)) : -1;
    endfunction

    function automatic int slice_at(int lvl);
        for (int k = 1; k < STAGES; k++)
            if ((k * LEVELS) / STAGES == lvl) return k;
        return 0;
    endfunction

    if (WIDTH < 2 || WIDTH > 128 || TOPOLOGY < 0 || TOPOLOGY > 2 || STAGES < 1 || STAGES > LEVELS) begin : g_bad_param
        $error("prefix_adder_pipe: WIDTH/TOPOLOGY/STAGES out of range");
    end

    logic [STAGES:1]   v;
    logic [STAGES:1]   vi;
    logic [STAGES+1:1] ld;

    always_comb begin
        ld = '0;
        vi = '0;
        ld[STAGES+1] = out_ready;
        for (int k = STAGES; k >= 1; k--) ld[k] = !v[k] || ld[k+1];
        vi[1] = in_valid;
        for (int k = 2; k <= STAGES; k++) vi[k] = v[k-1];
    end

    assign in_ready  = ld[1];
    assign out_valid = v[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++)
                if (ld[k]) v[k] <= vi[k];
        end
    end

    // gq/pq: group generate/propagate after each level; xq: bitwise propagate kept for the sum.
    logic [WIDTH-1:0] gq [0:LEVELS];
    logic [WIDTH-1:0] pq [0:LEVELS];
    logic [WIDTH-1:0] xq [0:LEVELS];
    logic             cq [0:LEVELS];
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g0;
    logic             ci;

`ifdef PREFIX_ADDER_SUB_EN
    assign bx = sub ? ~b : b;
    assign ci = sub | cin;
`else
    assign bx = b;
    assign ci = cin;
`endif

    assign g0    = a & bx;
    assign pq[0] = a ^ bx;
    assign xq[0] = a ^ bx;
    assign gq[0] = {g0[WIDTH-1:1], g0[0] | (pq[0][0] & ci)};
    assign cq[0] = ci;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int SK = slice_at(l);
        logic [WIDTH-1:0] gn, pn, go, po, xo;
        logic             co;

        for (genvar i = 0; i < WIDTH; i++) begin : g_col
            localparam int J = partner(l, i);
            if (J < 0) begin : g_pass
                assign gn[i] = gq[l-1][i];
                assign pn[i] = pq[l-1][i];
            end else begin : g_cell
                assign gn[i] = gq[l-1][i] | (pq[l-1][i] & gq[l-1][J]);
                assign pn[i] = pq[l-1][i] & pq[l-1][J];
            end
        end

        if (SK != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    go <= '0;
                    po <= '0;
                    xo <= '0;
                    co <= 1'b0;
                end else if (ld[SK] && vi[SK]) begin
                    go <= gn;
                    po <= pn;
                    xo <= xq[l-1];
                    co <= cq[l-1];
                end
            end
        end else begin : g_wire
            assign go = gn;
            assign po = pn;
            assign xo = xq[l-1];
            assign co = cq[l-1];
        end

        assign gq[l] = go;
        assign pq[l] = po;
        assign xq[l] = xo;
        assign cq[l] = co;
    end

    logic [WIDTH-1:0] carry;
    assign carry = {gq[LEVELS][WIDTH-2:0], cq[LEVELS]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
`ifdef PREFIX_ADDER_SUB_EN
            ovf  <= 1'b0;
`endif
        end else if (ld[STAGES] && vi[STAGES]) begin
            s    <= xq[LEVELS] ^ carry;
            cout <= gq[LEVELS][WIDTH-1];
`ifdef PREFIX_ADDER_SUB_EN
            ovf  <= gq[LEVELS][WIDTH-1] ^ gq[LEVELS][WIDTH-2];
`endif
        end
    end
endmodule
